switch_led_controller: RTL and testbench



---
 rtl/led_ctrl_pkg.sv | 23 ++
 rtl/switch_debounce.sv | 43 ++++
 rtl/switch_led_controller.sv | 129 ++++++++++++
 tb/tb_switch_led_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding, LED entry patterns and the chase rotate helper
// for the switch/LED controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [3:0] CHASE_INIT = 4'b0001;
  localparam logic [3:0] BLINK_INIT = 4'b1111;

  // up moves the lit LED from bit0 towards bit3
  function automatic logic [3:0] rotate(
    input logic [3:0] p,
    input logic       up
  );
    return up ? {p[2:0], p[3]} : {p[0], p[3:1]};
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Per-switch debouncer: counts clocks of raw/level disagreement and
// emits a one-cycle pulse after the debounced level falls.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_Count;
  logic          r_Level;
  logic          r_Level_q;
  logic          r_Release;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Count   <= '0;
      r_Level   <= 1'b0;
      r_Level_q <= 1'b0;
      r_Release <= 1'b0;
    end else begin
      r_Level_q <= r_Level;
      r_Release <= r_Level_q & ~r_Level;
      if (i_Switch == r_Level) begin
        r_Count <= '0;
      end else if (r_Count == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_Level <= i_Switch;
        r_Count <= '0;
      end else begin
        r_Count <= r_Count + 1'b1;
      end
    end
  end

  assign o_Level   = r_Level;
  assign o_Release = r_Release;

endmodule

// File: rtl/switch_led_controller.sv
// Four-switch LED sequencer: SW1 release cycles OFF/MANUAL/CHASE/BLINK,
// SW2..SW4 releases act inside the current mode.
import led_ctrl_pkg::*;

module switch_led_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_CYCLES     = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [3:0]    w_Raw;
  logic [3:0]    w_Level;
  logic [3:0]    w_Release;
  logic          w_Tc;
  logic          w_Up_Next;
  logic [3:1]    w_Manual_Next;

  mode_e         r_Mode;
  logic [3:1]    r_Manual;
  logic [3:0]    r_LED;
  logic          r_Up;
  logic          r_Run;
  logic [TW-1:0] r_Timer;

  assign w_Raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar i = 0; i < 4; i++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Switch (w_Raw[i]),
      .o_Level  (w_Level[i]),
      .o_Release(w_Release[i])
    );
  end

  assign w_Tc          = (r_Timer == TW'(STEP_CYCLES - 1));
  assign w_Up_Next     = r_Up ^ w_Release[1];
  assign w_Manual_Next = r_Manual ^ w_Release[3:1];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Mode   <= MODE_OFF;
      r_Manual <= '0;
      r_LED    <= '0;
      r_Up     <= 1'b1;
      r_Run    <= 1'b1;
      r_Timer  <= '0;
    end else if (w_Release[0]) begin
      // mode advance swallows any same-cycle SW2..SW4 release
      r_Timer <= '0;
      unique case (r_Mode)
        MODE_OFF: begin
          r_Mode <= MODE_MANUAL;
          r_LED  <= {r_Manual, 1'b1};
        end
        MODE_MANUAL: begin
          r_Mode <= MODE_CHASE;
          r_LED  <= CHASE_INIT;
          r_Up   <= 1'b1;
          r_Run  <= 1'b1;
        end
        MODE_CHASE: begin
          r_Mode <= MODE_BLINK;
          r_LED  <= BLINK_INIT;
        end
        MODE_BLINK: begin
          r_Mode <= MODE_OFF;
          r_LED  <= '0;
        end
      endcase
    end else begin
      unique case (r_Mode)
        MODE_OFF: begin
          r_Timer <= '0;
          r_LED   <= '0;
        end
        MODE_MANUAL: begin
          r_Timer  <= '0;
          r_Manual <= w_Manual_Next;
          r_LED    <= {w_Manual_Next, 1'b1};
        end
        MODE_CHASE: begin
          // a pause taking effect this cycle still lets this step occur
          r_Up  <= w_Up_Next;
          r_Run <= r_Run ^ w_Release[2];
          if (r_Run) begin
            if (w_Tc) begin
              r_Timer <= '0;
              r_LED   <= rotate(r_LED, w_Up_Next);
            end else begin
              r_Timer <= r_Timer + 1'b1;
            end
          end
        end
        MODE_BLINK: begin
          if (w_Tc) begin
            r_Timer <= '0;
            r_LED   <= ~r_LED;
          end else begin
            r_Timer <= r_Timer + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_LED_1 = r_LED[0];
  assign o_LED_2 = r_LED[1];
  assign o_LED_3 = r_LED[2];
  assign o_LED_4 = r_LED[3];
  assign o_Mode  = r_Mode;

endmodule

// File: tb/tb_switch_led_controller.sv
// Bench for switch_led_controller: mode-change scoreboard plus
// cycle-exact LED checks per scenario.
module tb_switch_led_controller;

  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = '0;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [1:0] o_Mode;
  logic [3:0] leds;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rel4   = 0;
  bit mon_en = 1'b0;

  logic [5:0] sb[$];
  logic [5:0] mon_exp;
  logic [1:0] last_mode;

  switch_led_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES    (STEP)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .o_LED_1   (o_LED_1),
    .o_LED_2   (o_LED_2),
    .o_LED_3   (o_LED_3),
    .o_LED_4   (o_LED_4),
    .o_Mode    (o_Mode)
  );

  assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every o_Mode change pops one expected {mode, leds}
  always @(negedge clk) begin
    if (dut.w_Release[3] === 1'b1) rel4++;
    if (mon_en && o_Mode !== last_mode) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: mode=%0d leds=%b, required no mode change",
                 o_Mode, leds);
      end else begin
        mon_exp = sb.pop_front();
        if ({o_Mode, leds} !== mon_exp) begin
          errors++;
          $display("FAIL sb_mode_change: got mode=%0d leds=%b, required mode=%0d leds=%b",
                   o_Mode, leds, mon_exp[5:4], mon_exp[3:0]);
        end
      end
    end
    last_mode = o_Mode;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [3:0] s, input int hold);
    @(negedge clk);
    sw = s;
    repeat (hold) @(negedge clk);
    sw = '0;
  endtask

  task automatic wait_mode(input logic [1:0] m, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (o_Mode === m) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic at(input int b, input int t);
    while (cyc < b + t) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sw  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_Mode !== 2'd0 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: mode=%0d leds=%b, required 0 0000", o_Mode, leds);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_Mode !== 2'd0 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset: mode=%0d leds=%b, required 0 0000", o_Mode, leds);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_mode_advance;
    int n;
    sb.push_back({2'd1, 4'b0001});
    press(4'b0001, 10);
    wait_mode(2'd1, n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL release_latency: %0d clocks, required 6", n);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (o_Mode !== 2'd1 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL manual_entry: mode=%0d leds=%b, required 1 0001", o_Mode, leds);
    end
  endtask

  task automatic test_manual;
    int n;
    logic [5:0] seq [4];
    seq[0] = {2'd2, 4'b0001};
    seq[1] = {2'd3, 4'b1111};
    seq[2] = {2'd0, 4'b0000};
    seq[3] = {2'd1, 4'b0101};
    press(4'b0100, 2);
    repeat (10) @(negedge clk);
    checks++;
    if (leds !== 4'b0001) begin
      errors++;
      $display("FAIL glitch_reject: leds=%b, required 0001", leds);
    end
    press(4'b0100, 6);
    repeat (10) @(negedge clk);
    checks++;
    if (leds !== 4'b0101) begin
      errors++;
      $display("FAIL manual_sw3: leds=%b, required 0101", leds);
    end
    press(4'b1010, 6);
    repeat (10) @(negedge clk);
    checks++;
    if (leds !== 4'b1111) begin
      errors++;
      $display("FAIL manual_sw2_sw4: leds=%b, required 1111", leds);
    end
    press(4'b1010, 6);
    repeat (10) @(negedge clk);
    checks++;
    if (leds !== 4'b0101) begin
      errors++;
      $display("FAIL manual_sw2_sw4_back: leds=%b, required 0101", leds);
    end
    for (int i = 0; i < 4; i++) begin
      sb.push_back(seq[i]);
      press(4'b0001, 6);
      wait_mode(seq[i][5:4], n);
      checks++;
      if (n < 0) begin
        errors++;
        $display("FAIL mode_cycle_%0d: mode=%0d, required %0d", i, o_Mode, seq[i][5:4]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== 4'b0101) begin
      errors++;
      $display("FAIL manual_retained: leds=%b, required 0101", leds);
    end
  endtask

  task automatic test_chase;
    int n;
    int b;
    int tt [9];
    logic [3:0] ev [9];
    sb.push_back({2'd2, 4'b0001});
    press(4'b0001, 6);
    wait_mode(2'd2, n);
    b = cyc;
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL chase_enter: mode=%0d, required 2", o_Mode);
    end
    tt = '{8, 16, 24, 32, 40, 48, 56, 64, 90};
    ev = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000,
           4'b0100, 4'b0010, 4'b0010, 4'b0010};
    for (int i = 0; i < 9; i++) begin
      at(b, tt[i]);
      checks++;
      if (leds !== ev[i]) begin
        errors++;
        $display("FAIL chase_t%0d: leds=%b, required %b", tt[i], leds, ev[i]);
      end
      if (tt[i] == 24) sw = 4'b0010;
      if (tt[i] == 48) sw = 4'b0100;
      if (tt[i] == 24 || tt[i] == 48) begin
        at(b, tt[i] + 5);
        sw = '0;
      end
    end
    at(b, 91);
    sw = 4'b0100;
    at(b, 96);
    sw = '0;
    at(b, 106);
    checks++;
    if (leds !== 4'b0010) begin
      errors++;
      $display("FAIL chase_resume_hold: leds=%b, required 0010", leds);
    end
    at(b, 107);
    checks++;
    if (leds !== 4'b0001) begin
      errors++;
      $display("FAIL chase_resume_step: leds=%b, required 0001", leds);
    end
  endtask

  task automatic test_blink;
    int n;
    int b;
    sb.push_back({2'd3, 4'b1111});
    press(4'b0001, 6);
    wait_mode(2'd3, n);
    b = cyc;
    checks++;
    if (n < 0 || leds !== 4'b1111) begin
      errors++;
      $display("FAIL blink_enter: mode=%0d leds=%b, required 3 1111", o_Mode, leds);
    end
    at(b, 7);
    checks++;
    if (leds !== 4'b1111) begin
      errors++;
      $display("FAIL blink_hold: leds=%b, required 1111", leds);
    end
    at(b, 8);
    checks++;
    if (leds !== 4'b0000) begin
      errors++;
      $display("FAIL blink_off: leds=%b, required 0000", leds);
    end
    at(b, 16);
    checks++;
    if (leds !== 4'b1111) begin
      errors++;
      $display("FAIL blink_on: leds=%b, required 1111", leds);
    end
    sb.push_back({2'd0, 4'b0000});
    press(4'b0001, 6);
    wait_mode(2'd0, n);
    checks++;
    if (n < 0 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL off_enter: mode=%0d leds=%b, required 0 0000", o_Mode, leds);
    end
    press(4'b1110, 6);
    repeat (15) @(negedge clk);
    checks++;
    if (o_Mode !== 2'd0 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL off_ignore: mode=%0d leds=%b, required 0 0000", o_Mode, leds);
    end
  endtask

  task automatic test_simultaneous;
    int n;
    int b;
    sb.push_back({2'd1, 4'b0101});
    press(4'b0001, 6);
    wait_mode(2'd1, n);
    sb.push_back({2'd2, 4'b0001});
    press(4'b0011, 6);
    wait_mode(2'd2, n);
    b = cyc;
    checks++;
    if (n < 0 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL sim_enter: mode=%0d leds=%b, required 2 0001", o_Mode, leds);
    end
    at(b, 8);
    checks++;
    if (leds !== 4'b0010) begin
      errors++;
      $display("FAIL sim_dir_up: leds=%b, required 0010", leds);
    end
  endtask

  task automatic test_reset_mid;
    int r0;
    sw = 4'b1000;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_Mode !== 2'd0 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: mode=%0d leds=%b, required 0 0000", o_Mode, leds);
    end
    r0 = rel4;
    repeat (10) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (rel4 !== r0) begin
      errors++;
      $display("FAIL reset_held_event: %0d events, required 0", rel4 - r0);
    end
    sw = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (rel4 !== r0 + 1) begin
      errors++;
      $display("FAIL reset_release_event: %0d events, required 1", rel4 - r0);
    end
    checks++;
    if (o_Mode !== 2'd0 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL reset_after_release: mode=%0d leds=%b, required 0 0000",
               o_Mode, leds);
    end
  endtask

  initial begin
    test_reset();
    test_mode_advance();
    test_manual();
    test_chase();
    test_blink();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
